// File: rtl/gpio_cfg_pkg.sv
// gpio_cfg_pkg: shared pad-config constants and serial-load sequencer state encoding
package gpio_cfg_pkg;
   localparam int CFG_WIDTH_DEF = 10;
   localparam int MGMT_EN = 0;
   localparam int OE_OVR = 1;
   localparam int IE = 2;
   localparam logic [CFG_WIDTH_DEF-1:0] PAD_DEFAULT = CFG_WIDTH_DEF'((1 << MGMT_EN) | (1 << OE_OVR) | (1 << IE));
   typedef enum logic [2:0] {IDLE, SHIFT_LO, SHIFT_HI, LOAD_HI, LOAD_LO, DONE} seq_state_t;
   function automatic logic timed(input seq_state_t s);
      return s inside {SHIFT_LO, SHIFT_HI, LOAD_HI, LOAD_LO};
   endfunction
endpackage

// File: rtl/gpio_serial_shifter.sv
// gpio_serial_shifter: MSB-first shift register with clock divider and bit counter
module gpio_serial_shifter #(
   parameter int N = 20,
   parameter int CLK_DIV = 2
)(
   input  logic         clk,
   input  logic         resetn,
   input  logic         load,
   input  logic [N-1:0] load_data,
   input  logic         run,
   input  logic         shift,
   output logic         div_end,
   output logic         last_bit,
   output logic         sdata
);
   localparam int DW = $clog2(CLK_DIV + 1);
   localparam int BW = $clog2(N + 1);
   logic [N-1:0] sr;
   logic [DW-1:0] div;
   logic [BW-1:0] cnt;
   assign div_end = div == DW'(CLK_DIV - 1);
   assign last_bit = cnt == BW'(N - 1);
   assign sdata = sr[N-1];
   always_ff @(posedge clk) begin
      if (!resetn) begin
         sr <= '0;
         div <= '0;
         cnt <= '0;
      end else if (load) begin
         sr <= load_data;
         div <= '0;
         cnt <= '0;
      end else begin
         div <= run ? (div_end ? '0 : div + 1'b1) : '0;
         if (shift) begin
            sr <= {sr[N-2:0], 1'b0};
            cnt <= cnt + 1'b1;
         end
      end
   end
endmodule

// File: rtl/gpio_defaults_sequencer.sv
// gpio_defaults_sequencer: writable per-pad config shadow with parallel view and serial chain loader
module gpio_defaults_sequencer import gpio_cfg_pkg::*; #(
   parameter int NUM_GPIO = 38,
   parameter int CFG_WIDTH = CFG_WIDTH_DEF,
   parameter logic [NUM_GPIO*CFG_WIDTH-1:0] DEFAULTS = {NUM_GPIO{CFG_WIDTH'(PAD_DEFAULT)}},
   parameter int CLK_DIV = 2,
   parameter bit AUTO_START = 1'b1,
   localparam int IDX_W = NUM_GPIO > 1 ? $clog2(NUM_GPIO) : 1,
   localparam int N = NUM_GPIO * CFG_WIDTH
)(
   input  logic                 clk,
   input  logic                 resetn,
   input  logic                 start,
   input  logic                 wr_en,
   input  logic [IDX_W-1:0]     wr_idx,
   input  logic [CFG_WIDTH-1:0] wr_data,
   output logic                 wr_err,
   output logic [N-1:0]         gpio_defaults,
   output logic                 serial_clock,
   output logic                 serial_data,
   output logic                 serial_load,
   output logic                 busy,
   output logic                 done
);
   seq_state_t state, nxt;
   logic [N-1:0] shadow, shadow_nxt;
   logic first, go, wr_ok, div_end, last_bit;
   assign go = start || (AUTO_START && first);
   assign wr_ok = wr_en && state == IDLE && int'(wr_idx) < NUM_GPIO;
   assign gpio_defaults = shadow;
   always_comb begin
      shadow_nxt = shadow;
      if (wr_ok) shadow_nxt[int'(wr_idx)*CFG_WIDTH +: CFG_WIDTH] = wr_data;
   end
   always_comb begin
      nxt = state;
      case (state)
         IDLE:     nxt = go ? SHIFT_LO : IDLE;
         SHIFT_LO: nxt = div_end ? SHIFT_HI : SHIFT_LO;
         SHIFT_HI: nxt = div_end ? (last_bit ? LOAD_HI : SHIFT_LO) : SHIFT_HI;
         LOAD_HI:  nxt = div_end ? LOAD_LO : LOAD_HI;
         LOAD_LO:  nxt = div_end ? DONE : LOAD_LO;
         default:  nxt = IDLE;
      endcase
   end
   always_ff @(posedge clk) begin
      if (!resetn) begin
         state <= IDLE;
         shadow <= DEFAULTS;
         first <= 1'b1;
         wr_err <= 1'b0;
         busy <= 1'b0;
         done <= 1'b0;
         serial_clock <= 1'b0;
         serial_load <= 1'b0;
      end else begin
         state <= nxt;
         shadow <= shadow_nxt;
         first <= 1'b0;
         wr_err <= wr_en && !wr_ok;
         busy <= timed(nxt);
         done <= nxt == DONE;
         serial_clock <= nxt == SHIFT_HI;
         serial_load <= nxt == LOAD_HI;
      end
   end
   gpio_serial_shifter #(.N(N), .CLK_DIV(CLK_DIV)) u_shifter (
      .clk       (clk),
      .resetn    (resetn),
      .load      (state == IDLE && go),
      .load_data (shadow_nxt),
      .run       (timed(state)),
      .shift     (state == SHIFT_HI && div_end && !last_bit),
      .div_end   (div_end),
      .last_bit  (last_bit),
      .sdata     (serial_data)
   );
endmodule

// File: tb/tb_gpio_defaults_sequencer.sv
// tb_gpio_defaults_sequencer: directed scenario tasks against three sequencer configurations
module tb_gpio_defaults_sequencer;
   logic clk = 1'b0;
   logic resetn = 1'b0;
   always #5 clk = ~clk;
   int checks = 0;
   int failures = 0;
   logic start1 = 0, wr_en1 = 0, wr_err1, sc1, sd1, sl1, busy1, done1;
   logic [0:0] wr_idx1 = '0;
   logic [3:0] wr_data1 = '0;
   logic [7:0] gd1;
   logic start2 = 0, wr_en2 = 0, wr_err2, sc2, sd2, sl2, busy2, done2;
   logic [0:0] wr_idx2 = '0;
   logic [3:0] wr_data2 = '0;
   logic [7:0] gd2;
   logic start6 = 0, wr_en6 = 0, wr_err6, sc6, sd6, sl6, busy6, done6;
   logic [5:0] wr_idx6 = '0;
   logic [9:0] wr_data6 = '0;
   logic [379:0] gd6, def6;

   gpio_defaults_sequencer #(.NUM_GPIO(2), .CFG_WIDTH(4), .DEFAULTS(8'hA5), .CLK_DIV(1), .AUTO_START(1)) d1 (
      .clk(clk), .resetn(resetn), .start(start1), .wr_en(wr_en1), .wr_idx(wr_idx1), .wr_data(wr_data1),
      .wr_err(wr_err1), .gpio_defaults(gd1), .serial_clock(sc1), .serial_data(sd1), .serial_load(sl1),
      .busy(busy1), .done(done1));
   gpio_defaults_sequencer #(.NUM_GPIO(2), .CFG_WIDTH(4), .DEFAULTS(8'hA5), .CLK_DIV(1), .AUTO_START(0)) d2 (
      .clk(clk), .resetn(resetn), .start(start2), .wr_en(wr_en2), .wr_idx(wr_idx2), .wr_data(wr_data2),
      .wr_err(wr_err2), .gpio_defaults(gd2), .serial_clock(sc2), .serial_data(sd2), .serial_load(sl2),
      .busy(busy2), .done(done2));
   gpio_defaults_sequencer #(.NUM_GPIO(38), .CFG_WIDTH(10), .CLK_DIV(3), .AUTO_START(0)) d6 (
      .clk(clk), .resetn(resetn), .start(start6), .wr_en(wr_en6), .wr_idx(wr_idx6), .wr_data(wr_data6),
      .wr_err(wr_err6), .gpio_defaults(gd6), .serial_clock(sc6), .serial_data(sd6), .serial_load(sl6),
      .busy(busy6), .done(done6));

   task automatic step;
      @(posedge clk);
      #1;
   endtask

   task automatic collect(input int which, output logic [7:0] bits, output int nbits, output int busy_n,
                          output int load_n, output int done_n, output bit done_ok, output bit timeout);
      logic sc, sd, sl, bz, dn, prev_sc, prev_bz;
      bits = '0; nbits = 0; busy_n = 0; load_n = 0; done_n = 0; done_ok = 0; timeout = 1;
      prev_sc = 0; prev_bz = 0;
      for (int c = 0; c < 60; c++) begin
         step;
         start1 = 0; start2 = 0; wr_en1 = 0; wr_en2 = 0;
         sc = which == 1 ? sc1 : sc2;
         sd = which == 1 ? sd1 : sd2;
         sl = which == 1 ? sl1 : sl2;
         bz = which == 1 ? busy1 : busy2;
         dn = which == 1 ? done1 : done2;
         if (sc && !prev_sc) begin
            bits = {bits[6:0], sd};
            nbits++;
         end
         busy_n += int'(bz);
         load_n += int'(sl);
         if (dn) begin
            done_n++;
            done_ok = prev_bz && !bz;
         end
         if (done_n > 0 && !dn) begin
            timeout = 0;
            break;
         end
         prev_sc = sc;
         prev_bz = bz;
      end
   endtask

   task automatic test_reset;
      resetn = 0;
      repeat (3) step;
      resetn = 1;
      checks++; if (gd1 !== 8'hA5) begin failures++; $display("FAIL reset_gd1 got=%h exp=a5", gd1); end
      checks++; if ({busy1, sc1, sd1, sl1, done1, wr_err1} !== 6'b0) begin failures++; $display("FAIL reset_outs1 got=%b exp=000000", {busy1, sc1, sd1, sl1, done1, wr_err1}); end
      checks++; if (gd2 !== 8'hA5) begin failures++; $display("FAIL reset_gd2 got=%h exp=a5", gd2); end
      checks++; if (gd6 !== def6) begin failures++; $display("FAIL reset_gd6 got=%h exp=%h", gd6, def6); end
   endtask

   task automatic test_auto_start;
      logic [7:0] bits; int nb, bn, ln, dn; bit ok, to;
      collect(1, bits, nb, bn, ln, dn, ok, to);
      checks++; if (bits !== 8'hA5 || nb !== 8) begin failures++; $display("FAIL auto_bits got=%h/%0d exp=a5/8", bits, nb); end
      checks++; if (bn !== 18) begin failures++; $display("FAIL auto_busy got=%0d exp=18", bn); end
      checks++; if (ln !== 1) begin failures++; $display("FAIL auto_load got=%0d exp=1", ln); end
      checks++; if (dn !== 1 || !ok || to) begin failures++; $display("FAIL auto_done got=%0d/%0d/%0d exp=1/1/0", dn, ok, to); end
   endtask

   task automatic test_write_start;
      logic [7:0] bits; int nb, bn, ln, dn; bit ok, to;
      step; step;
      checks++; if (busy2 !== 1'b0) begin failures++; $display("FAIL no_auto got=%b exp=0", busy2); end
      wr_en2 = 1; wr_idx2 = 1'b0; wr_data2 = 4'hC;
      step;
      wr_en2 = 0;
      checks++; if (gd2 !== 8'hAC || wr_err2 !== 1'b0) begin failures++; $display("FAIL wr_gd2 got=%h/%b exp=ac/0", gd2, wr_err2); end
      start2 = 1;
      collect(2, bits, nb, bn, ln, dn, ok, to);
      checks++; if (bits !== 8'hAC || nb !== 8) begin failures++; $display("FAIL start_bits got=%h/%0d exp=ac/8", bits, nb); end
      checks++; if (bn !== 18 || dn !== 1 || to) begin failures++; $display("FAIL start_busy got=%0d/%0d/%0d exp=18/1/0", bn, dn, to); end
   endtask

   task automatic test_wr_err;
      bit seen;
      start2 = 1;
      step;
      start2 = 0;
      step; step;
      wr_en2 = 1; wr_idx2 = 1'b1; wr_data2 = 4'hF;
      step;
      wr_en2 = 0;
      checks++; if (wr_err2 !== 1'b1 || gd2 !== 8'hAC) begin failures++; $display("FAIL busy_wr got=%b/%h exp=1/ac", wr_err2, gd2); end
      step;
      checks++; if (wr_err2 !== 1'b0) begin failures++; $display("FAIL busy_wr_pulse got=%b exp=0", wr_err2); end
      seen = 0;
      for (int c = 0; c < 40 && !seen; c++) begin
         step;
         seen = done2;
      end
      checks++; if (!seen) begin failures++; $display("FAIL busy_wr_done got=0 exp=1"); end
      step;
      wr_en6 = 1; wr_idx6 = 6'd45; wr_data6 = 10'h3FF;
      step;
      wr_en6 = 0;
      checks++; if (wr_err6 !== 1'b1 || gd6 !== def6) begin failures++; $display("FAIL bad_idx got=%b exp=1", wr_err6); end
      step;
      checks++; if (wr_err6 !== 1'b0) begin failures++; $display("FAIL bad_idx_pulse got=%b exp=0", wr_err6); end
      wr_en6 = 1; wr_idx6 = 6'd37; wr_data6 = 10'h2AA;
      step;
      wr_en6 = 0;
      checks++; if (gd6[379:370] !== 10'h2AA || gd6[369:0] !== def6[369:0] || wr_err6 !== 1'b0) begin failures++; $display("FAIL top_idx got=%h/%b exp=2aa/0", gd6[379:370], wr_err6); end
   endtask

   task automatic test_same_cycle;
      logic [7:0] bits; int nb, bn, ln, dn; bit ok, to;
      wr_en2 = 1; wr_idx2 = 1'b1; wr_data2 = 4'h3; start2 = 1;
      collect(2, bits, nb, bn, ln, dn, ok, to);
      checks++; if (bits !== 8'h3C || nb !== 8) begin failures++; $display("FAIL same_bits got=%h/%0d exp=3c/8", bits, nb); end
      checks++; if (gd2 !== 8'h3C) begin failures++; $display("FAIL same_gd2 got=%h exp=3c", gd2); end
   endtask

   task automatic test_back_to_back_long;
      int bn, ln, dn, extra;
      bn = 0; ln = 0; dn = 0; extra = 0;
      start6 = 1;
      for (int c = 0; c < 3000 && dn == 0; c++) begin
         step;
         start6 = (c == 99);
         bn += int'(busy6);
         ln += int'(sl6);
         if (done6) dn++;
      end
      start6 = 0;
      checks++; if (bn !== 2286) begin failures++; $display("FAIL long_busy got=%0d exp=2286", bn); end
      checks++; if (ln !== 3 || dn !== 1) begin failures++; $display("FAIL long_load got=%0d/%0d exp=3/1", ln, dn); end
      repeat (5) begin
         step;
         extra += int'(busy6) + int'(done6);
      end
      checks++; if (extra !== 0) begin failures++; $display("FAIL long_no_queue got=%0d exp=0", extra); end
   endtask

   task automatic test_reset_abort;
      logic [7:0] bits; int nb, bn, ln, dn; bit ok, to;
      logic prev;
      int cnt;
      wr_en1 = 1; wr_idx1 = 1'b0; wr_data1 = 4'h0;
      step;
      wr_en1 = 0;
      checks++; if (gd1 !== 8'hA0) begin failures++; $display("FAIL abort_wr got=%h exp=a0", gd1); end
      start1 = 1;
      prev = 0; cnt = 0;
      for (int c = 0; c < 40 && cnt < 5; c++) begin
         step;
         start1 = 0;
         if (sc1 && !prev) cnt++;
         prev = sc1;
      end
      checks++; if (cnt !== 5 || busy1 !== 1'b1) begin failures++; $display("FAIL abort_reach got=%0d/%b exp=5/1", cnt, busy1); end
      resetn = 0;
      step;
      checks++; if ({sc1, sd1, sl1, busy1, done1} !== 5'b0) begin failures++; $display("FAIL abort_outs got=%b exp=00000", {sc1, sd1, sl1, busy1, done1}); end
      checks++; if (gd1 !== 8'hA5) begin failures++; $display("FAIL abort_gd1 got=%h exp=a5", gd1); end
      resetn = 1;
      collect(1, bits, nb, bn, ln, dn, ok, to);
      checks++; if (bits !== 8'hA5 || bn !== 18 || dn !== 1 || to) begin failures++; $display("FAIL abort_reload got=%h/%0d/%0d/%0d exp=a5/18/1/0", bits, bn, dn, to); end
   endtask

   initial begin
      def6 = {38{10'h007}};
      test_reset;
      test_auto_start;
      test_write_start;
      test_wr_err;
      test_same_cycle;
      test_back_to_back_long;
      test_reset_abort;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
